// File: rtl/ebus_timer_dev_if.sv
// EBUS bundle between the EBOX (master) and the interval timer device (slave).
// Vectors are MSB-first: PDP bit k of a W-bit field is stored at index W-1-k.
package ebus_pkg;
    typedef struct packed {
        logic        driving;
        logic [35:0] data;
    } tEBUSdriver;
endpackage

interface ebus_timer_dev_if;
    import ebus_pkg::*;

    logic [6:0]  ebus_cs;
    logic [2:0]  ebus_func;
    logic        ebus_demand;
    logic [35:0] ebus_data_in;
    logic        ebus_parity_in;
    tEBUSdriver  EBUSdriver;
    logic        ebus_xfer;
    logic        ebus_parity_out;
    logic [7:0]  ebus_pi;

    // Handshake: the master raises demand with cs/func/data stable and holds it
    // until it has seen xfer; the slave holds xfer (and read data) until demand drops.
    modport master (
        output ebus_cs, ebus_func, ebus_demand, ebus_data_in, ebus_parity_in,
        input  EBUSdriver, ebus_xfer, ebus_parity_out, ebus_pi
    );
    modport slave (
        input  ebus_cs, ebus_func, ebus_demand, ebus_data_in, ebus_parity_in,
        output EBUSdriver, ebus_xfer, ebus_parity_out, ebus_pi
    );
endinterface

// File: rtl/ebus_timer_dev.sv
// KL10 EBUS programmable interval timer: CONO/CONI/DATAO/DATAI responder with PI request.
// Optional EBUS parity generation/checking is enabled with macro EBUS_PARITY_EN.
module ebus_timer_dev #(
    parameter logic [6:0] DEVNUM = 7'o070
) (
    input  logic            clk,
    input  logic            reset_l,
    ebus_timer_dev_if.slave bus,
    output logic [1:0]      o_state
);
    // CONO/CONI bit positions, converted from PDP numbering (bit 0 = MSB).
    localparam int B_CLR_PERR = 35 - 24;
    localparam int B_CLR_DONE = 35 - 25;
    localparam int B_SET_RUN  = 35 - 26;
    localparam int B_CLR_RUN  = 35 - 27;

    localparam logic [1:0] F_CONO  = 2'd0;
    localparam logic [1:0] F_DATAO = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACT  = 2'd1,
        S_XFER = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_func;
    logic        w_hit;
    logic [35:0] w_d;
    logic        w_wr_cono;
    logic        w_wr_datao;
    logic        w_rd_act;
    logic        w_expire;

    logic [17:0] r_interval;
    logic [17:0] r_count;
    logic        r_run;
    logic        r_done;
    logic [2:0]  r_pia;
    logic        w_perr;

    logic        r_xfer;
    logic        r_driving;
    logic [35:0] r_rdata;
    logic [35:0] w_coni;
    logic [35:0] w_datai;
    logic [7:0]  w_pi;

    assign w_d        = bus.ebus_data_in;
    assign w_hit      = bus.ebus_demand && (bus.ebus_cs == DEVNUM) && !bus.ebus_func[2];
    assign w_wr_cono  = (r_state == S_ACT) && (r_func == F_CONO);
    assign w_wr_datao = (r_state == S_ACT) && (r_func == F_DATAO);
    assign w_rd_act   = (r_state == S_ACT) && r_func[0];
    assign w_expire   = r_run && (r_count == 18'd1);
    assign o_state    = r_state;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state <= S_IDLE;
            r_func  <= 2'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_hit) r_func <= bus.ebus_func[1:0];
        end
    end

    // ACT always lasts one clock, even if demand has already dropped.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_hit) w_next = S_ACT;
            S_ACT:   w_next = S_XFER;
            S_XFER:  if (!bus.ebus_demand) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // A DATAO wins over the reload, and an expiry wins over a CONO clear-done.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_interval <= 18'd0;
            r_count    <= 18'd0;
            r_run      <= 1'b0;
            r_done     <= 1'b0;
            r_pia      <= 3'd0;
        end else begin
            if (w_wr_datao) begin
                r_interval <= w_d[17:0];
                r_count    <= w_d[17:0];
            end else if (r_run && r_count != 18'd0) begin
                r_count <= w_expire ? r_interval : r_count - 18'd1;
            end
            if (w_expire) r_done <= 1'b1;
            else if (w_wr_cono && w_d[B_CLR_DONE]) r_done <= 1'b0;
            if (w_wr_cono) begin
                r_pia <= w_d[2:0];
                if (w_d[B_CLR_RUN]) r_run <= 1'b0;
                else if (w_d[B_SET_RUN]) r_run <= 1'b1;
            end
        end
    end

`ifdef EBUS_PARITY_EN
    logic r_perr;
    logic w_perr_hit;

    assign w_perr_hit = (w_wr_cono || w_wr_datao) && ~^{w_d, bus.ebus_parity_in};

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) r_perr <= 1'b0;
        else if (w_perr_hit) r_perr <= 1'b1;
        else if (w_wr_cono && w_d[B_CLR_PERR]) r_perr <= 1'b0;
    end

    assign w_perr              = r_perr;
    assign bus.ebus_parity_out = r_driving & ~^r_rdata;
`else
    logic w_unused;
    assign w_unused            = ^{bus.ebus_parity_in, w_d[35:18], w_d[B_CLR_PERR], w_d[7:3]};
    assign w_perr              = 1'b0;
    assign bus.ebus_parity_out = 1'b0;
`endif

    assign w_coni  = {28'd0, w_perr, r_run, r_done, 2'b00, r_pia};
    assign w_datai = {18'd0, r_count};

    // Read words are snapshotted in ACT and held until demand drops.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_xfer    <= 1'b0;
            r_driving <= 1'b0;
            r_rdata   <= 36'd0;
        end else begin
            r_xfer <= (w_next == S_XFER);
            if (w_rd_act) begin
                r_driving <= 1'b1;
                r_rdata   <= r_func[1] ? w_datai : w_coni;
            end else if (w_next != S_XFER) begin
                r_driving <= 1'b0;
                r_rdata   <= 36'd0;
            end
        end
    end

    always_comb begin
        w_pi = 8'd0;
        if (r_done && r_pia != 3'd0) w_pi[3'd7 - r_pia] = 1'b1;
    end

    assign bus.ebus_xfer  = r_xfer;
    assign bus.ebus_pi    = w_pi;
    assign bus.EBUSdriver = '{driving: r_driving, data: r_rdata};
endmodule

// File: doc/ebus_timer_dev.md
# ebus_timer_dev

EBUS I/O device responder implementing a programmable interval timer for the KL10PV. It answers EBOX-initiated CONO/CONI/DATAO/DATAI cycles addressed to its device code with the demand/xfer handshake. It raises a PI request on its programmed level when the interval expires. It supplies the `tEBUSdriver` data and `xfer`/`pi` lines that the top level currently ties to zero.

## Interface

Parameters:
- `DEVNUM`, default 7'o070: device code compared against `ebus_cs[0:6]`.

Ports:
- `clk`  in  1: system clock; all state is on the rising edge.
- `reset_l`  in  1: asynchronous, active-low reset.
- `ebus_cs`  in  7 [0:6]: controller/device select.
- `ebus_func`  in  3 [0:2]: function code. 0 = CONO, 1 = CONI, 2 = DATAO, 3 = DATAI; all others ignored.
- `ebus_demand`  in  1: initiator demand.
- `ebus_data_in`  in  36 [0:35]: EBUS data, bit 0 is the MSB.
- `ebus_parity_in`  in  1: EBUS parity. Used only with `EBUS_PARITY_EN`.
- `EBUSdriver`  out  `tEBUSdriver`: `.driving` and `.data[0:35]` going to the top-level EBUS mux.
- `ebus_xfer`  out  1: transfer acknowledge.
- `ebus_parity_out`  out  1: odd parity over the driven data.
- `ebus_pi`  out  8 [0:7]: PI request lines. Level n appears on `ebus_pi[n]`; level 0 is never driven.

## Operation

Registers:
- `interval[18]`: reload value.
- `count[18]`: current count.
- `run`, `done`, `perr`: status flags.
- `pia[3]`: PI level.

CONO, using `ebus_data_in`:
- Bit 25 = 1 clears `done`.
- Bit 26 = 1 sets `run`.
- Bit 27 = 1 clears `run`. If bits 26 and 27 are both 1, the clear wins.
- Bit 24 = 1 clears `perr`.
- Bits 33:35 load `pia`.

CONI returns:
- Bit 28 = `perr`, bit 29 = `run`, bit 30 = `done`, bits 33:35 = `pia`.
- All other bits are 0.

DATAO:
- Bits 18:35 load both `interval` and `count`.
- Bits 0:17 are ignored.

DATAI returns `count` in bits 18:35, with 0 in bits 0:17.

Counter behaviour:
- While `run` is set, `count` decrements by 1 every clock.
- When `count` is 1 and decrements, `done` is set the next clock and `count` reloads from `interval` rather than becoming 0.
- If `interval` is 0 and `run` is set, `count` holds at 0 and `done` is never set.
- A DATAO that coincides with the expiry clock takes priority: the new value is loaded and `done` is still set.
- A CONO clear-done that coincides with an expiry leaves `done` = 1, because the expiry wins.

PI request:
- `ebus_pi[pia]` equals `done & (pia != 0)`.
- The output is combinational from registers and is glitch-free per clock.

Handshake FSM. State is held in registers; the outputs are registered.
- **IDLE**
  - Go to **ACT** when `ebus_demand` is 1, `ebus_cs == DEVNUM` and `ebus_func` is 0–3.
  - Ignore the cycle otherwise: no xfer, no driving.
- **ACT** (one clock)
  - Write functions (0, 2) latch `ebus_data_in` and update the registers at the end of this clock.
  - Read functions (1, 3) capture the read word into an output holding register.
  - Always go to **XFER**.
- **XFER**
  - Assert `ebus_xfer`.
  - For read functions, hold `driving` = 1 and present the captured data.
  - Go to **IDLE** when `ebus_demand` is 0.
- If `ebus_demand` drops while in **ACT**, the write still commits, then the FSM proceeds to **XFER** for one clock and returns to **IDLE**.

## Timing

Reset values:
- FSM in **IDLE**.
- `ebus_xfer` = 0, `EBUSdriver.driving` = 0, `EBUSdriver.data` = 0, `ebus_parity_out` = 0, `ebus_pi` = 0.
- `interval` = `count` = 0; `run` = `done` = `perr` = 0; `pia` = 0.

Cycle timing:
- Demand sampled high at edge N: ACT during N..N+1, and `ebus_xfer` and `driving` go high after edge N+1.
- Demand sampled low at edge M: `ebus_xfer` and `driving` go low after edge M. `data` returns to 0 on the same edge.
- Read data is stable for the whole time `driving` is 1. CONI and DATAI snapshots are taken in ACT and do not track the counter afterwards.
- Asserting reset mid-cycle drops `xfer`, `driving` and `pi` asynchronously. Any ACT commit in progress is discarded.

## Configuration

Macro `EBUS_PARITY_EN`.

Defined:
- `ebus_parity_out` is odd parity over `EBUSdriver.data[0:35]` while `driving` = 1, and 0 otherwise.
- A CONO or DATAO whose data plus `ebus_parity_in` has even total parity sets `perr`. The write is still performed.

Undefined:
- `ebus_parity_out` is constant 0.
- `ebus_parity_in` is ignored.
- `perr` is constant 0, and CONI bit 28 reads 0.

## Test plan

- **Reset:** hold `reset_l` = 0 for 3 clocks -> all outputs 0; CONI returns 36'o0.
- **DATAO then DATAI:** DATAO 36'o000000_000012, then DATAI -> bits 18:35 read 18'o12, `xfer` high 2 clocks after demand, `driving` drops on the clock demand is seen low.
- **Expiry and PI:**
  - Sequence: DATAO 5, then CONO with bit 26 set and `pia` = 3.
  - Expected: `done` sets exactly 5 clocks after `run` takes effect, and `ebus_pi` = 8'b0001_0000.
  - Then CONO with bit 25 set -> `pi` returns to 0 and `count` has reloaded to 5.
- **Wrong address:** demand with `cs` = `DEVNUM`^1, or `func` = 5 -> `xfer` and `driving` stay 0 for 20 clocks.
- **Simultaneous events:** CONO clear-done lands on the expiry clock -> `done` stays 1. DATAO 7 lands on the expiry clock -> `count` = 7 and `done` = 1.
- **Parity (with `EBUS_PARITY_EN`):**
  - DATAO with even total parity -> CONI bit 28 = 1.
  - CONI response -> `ebus_parity_out` makes odd total parity.
  - CONO with bit 24 set -> `perr` cleared.
